// File: rtl/valve_skid.sv
// Registered Maybe-valve: ctrl=1 items are discarded, ctrl=0 payloads pass through a
// 2-entry output FIFO. Includes a stall/drop gate and a saturating drop counter.
module valve_skid #(
   parameter int W_DATA    = 16,
   parameter int GATE_MODE = 0,
   parameter int W_CNT     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din_valid,
   input  logic [W_DATA:0]   din_data,
   output logic              din_ready,
   output logic              dout_valid,
   output logic [W_DATA-1:0] dout_data,
   input  logic              dout_ready,
   input  logic              gate,
   input  logic              cnt_clr,
   output logic [W_CNT-1:0]  drop_cnt
);
   localparam logic [W_CNT-1:0] CNT_ONE   = W_CNT'(1);
   localparam logic [W_CNT-1:0] CNT_MAX   = '1;
   localparam logic             GATE_DROP = (GATE_MODE == 1);

   logic [1:0]        occ;
   logic [W_DATA-1:0] head;
   logic [W_DATA-1:0] tail;
   logic [W_DATA-1:0] payload;
   logic              ctrl;
   logic              is_drop;
   logic              is_keep;
   logic              not_full;
   logic              push;
   logic              pop;
   logic              drop_hs;

   assign ctrl     = din_data[W_DATA];
   assign payload  = din_data[W_DATA-1:0];
   assign is_drop  = ctrl || (!gate && GATE_DROP);
   assign is_keep  = !ctrl && gate;
   assign not_full = (occ != 2'd2);

   // Ready is forced low during reset so nothing is consumed in that cycle.
   always_comb begin
      din_ready = 1'b0;
      if (!rst) begin
         din_ready = din_valid ? (is_drop || (is_keep && not_full)) : not_full;
      end
   end

   assign push       = din_valid && din_ready && is_keep;
   assign drop_hs    = din_valid && din_ready && is_drop;
   assign dout_valid = (occ != 2'd0);
   assign dout_data  = head;
   assign pop        = dout_valid && dout_ready && !rst;

   // Head is always the oldest entry; tail only holds data when occ==2.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else if (pop && push) begin
         if (occ == 2'd1) begin
            head <= payload;
         end else begin
            head <= tail;
            tail <= payload;
         end
      end else if (pop) begin
         head <= tail;
         occ  <= occ - 2'd1;
      end else if (push) begin
         if (occ == 2'd0) begin
            head <= payload;
         end else begin
            tail <= payload;
         end
         occ <= occ + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (cnt_clr) begin
         drop_cnt <= drop_hs ? CNT_ONE : '0;
      end else if (drop_hs && (drop_cnt != CNT_MAX)) begin
         drop_cnt <= drop_cnt + CNT_ONE;
      end
   end

endmodule
